// File: rtl/seg7_scan_driver.sv
// Multi-digit 7-segment driver: valid/ready binary capture, serial double-dabble BCD
// conversion, then free-running digit multiplex. Define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_driver #(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [WIDTH-1:0]  in_data,
   output logic              in_ready,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] dig_en,
   output logic              overflow
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

   localparam logic [63:0] LIMIT = pow10(DIGITS);

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'd0:    seg7 = 7'b1111110;
         4'd1:    seg7 = 7'b0110000;
         4'd2:    seg7 = 7'b1101101;
         4'd3:    seg7 = 7'b1111001;
         4'd4:    seg7 = 7'b0110011;
         4'd5:    seg7 = 7'b1011011;
         4'd6:    seg7 = 7'b1011111;
         4'd7:    seg7 = 7'b1110000;
         4'd8:    seg7 = 7'b1111111;
         4'd9:    seg7 = 7'b1110011;
         default: seg7 = 7'b0000001;
      endcase
   endfunction

   typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_e;
   state_e state_q, state_d;

   logic [WIDTH-1:0] sr_q, sr_d;
   logic [BW-1:0]    bcd_q, bcd_d, bcd_adj, disp_q, disp_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             flag_q, flag_d, ovf_q, ovf_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             xfer, last_shift, wrap;
   logic [3:0]       nib;
   logic             blank;

   assign xfer       = in_valid && in_ready;
   assign last_shift = (cnt_q == CW'(WIDTH - 1));

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (xfer) state_d = CONVERT;
         CONVERT: if (last_shift) state_d = LOAD;
         LOAD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready = (state_q == IDLE);
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++)
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
   end

   // Carry out of the top nibble is dropped; the elaboration-time limit flags that case.
   always_comb begin
      sr_d   = sr_q;
      bcd_d  = bcd_q;
      cnt_d  = cnt_q;
      flag_d = flag_q;
      disp_d = disp_q;
      ovf_d  = ovf_q;
      case (state_q)
         IDLE: if (xfer) begin
            sr_d   = in_data;
            bcd_d  = '0;
            cnt_d  = '0;
            flag_d = (64'(in_data) >= LIMIT);
         end
         CONVERT: begin
            bcd_d = {bcd_adj[BW-2:0], sr_q[WIDTH-1]};
            sr_d  = sr_q << 1;
            cnt_d = cnt_q + CW'(1);
         end
         LOAD: begin
            disp_d = bcd_q;
            ovf_d  = flag_q;
         end
         default: ;
      endcase
   end

   assign wrap = (presc_q == PW'(SCAN_DIV - 1));

   always_comb begin
      presc_d = wrap ? '0 : presc_q + PW'(1);
      idx_d   = idx_q;
      if (wrap) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q    <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         flag_q  <= 1'b0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
         presc_q <= '0;
         idx_q   <= '0;
      end else begin
         sr_q    <= sr_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         flag_q  <= flag_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      nib = 4'(disp_q >> {idx_q, 2'b00});
`ifdef SEG7_LZB_EN
      // Blank when this digit and everything above it are zero; digit 0 always shows.
      blank = (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);
`else
      blank = 1'b0;
`endif
      if (ovf_q)      seg = 7'b0000001;
      else if (blank) seg = 7'b0000000;
      else            seg = seg7(nib);
      dig_en = DIGITS'(1) << idx_q;
   end

   assign overflow = ovf_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a 3-digit and a 2-digit instance on one clock/reset.
module tb_seg7_scan_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       vld0 = 1'b0, vld1 = 1'b0;
   logic [7:0] dat0 = '0, dat1 = '0;
   logic       rdy0, rdy1, ovf0, ovf1;
   logic [6:0] seg0, seg1;
   logic [2:0] den0;
   logic [1:0] den1;

   int checks = 0;
   int errors = 0;

`ifdef SEG7_LZB_EN
   localparam logic [6:0] LZ = 7'b0000000;
`else
   localparam logic [6:0] LZ = 7'b1111110;
`endif

   seg7_scan_driver #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld0), .in_data(dat0),
      .in_ready(rdy0), .seg(seg0), .dig_en(den0), .overflow(ovf0));

   seg7_scan_driver #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(4)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld1), .in_data(dat1),
      .in_ready(rdy1), .seg(seg1), .dig_en(den1), .overflow(ovf1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) until digit d of the selected instance is enabled, then compare seg.
   task automatic chk_dig(input string tag, input int inst, input int d, input logic [6:0] exp);
      logic [7:0] cur;
      logic [7:0] want;
      bit found;
      found = 0;
      want  = 8'(1 << d);
      for (int i = 0; i < 40 && !found; i++) begin
         cur = (inst == 0) ? {5'b0, den0} : {6'b0, den1};
         if (cur == want) found = 1;
         else step();
      end
      if (!found) chk({tag, "_timeout"}, 32'd0, 32'd1);
      else chk(tag, (inst == 0) ? seg0 : seg1, exp);
   endtask

   task automatic send(input int inst, input logic [7:0] v);
      bit rdy;
      rdy = 0;
      for (int i = 0; i < 50 && !rdy; i++) begin
         rdy = (inst == 0) ? rdy0 : rdy1;
         if (!rdy) step();
      end
      if (!rdy) chk("send_timeout", 32'd0, 32'd1);
      if (inst == 0) begin vld0 = 1'b1; dat0 = v; end
      else           begin vld1 = 1'b1; dat1 = v; end
      step();
      vld0 = 1'b0;
      vld1 = 1'b0;
   endtask

   task automatic chk_hold();
      int n;
      n = 0;
      for (int i = 0; i < 40 && den0 == 3'b001; i++) step();
      for (int i = 0; i < 40 && den0 != 3'b001; i++) step();
      while (den0 == 3'b001 && n < 40) begin
         n++;
         step();
      end
      chk("hold_cycles", n, 4);
   endtask

   initial begin
      // Reset held from time 0, checked before any clock edge.
      #3;
      chk("rst_ready", rdy0, 1);
      chk("rst_ovf", ovf0, 0);
      chk("rst_den", den0, 3'b001);
      chk("rst_seg", seg0, 7'b1111110);
      step();
      #4 rst_n = 1'b1;
      step();

      // 237 with 99 pending during conversion; 99 dropped before IDLE edge.
      vld0 = 1'b1; dat0 = 8'd237;
      step();
      dat0 = 8'd99;
      chk("busy_k0", rdy0, 0);
      for (int i = 1; i <= 8; i++) begin
         step();
         chk($sformatf("busy_k%0d", i), rdy0, 0);
      end
      step();
      chk("ready_k9", rdy0, 1);
      vld0 = 1'b0;
      step();
      chk("no_capture", rdy0, 1);
      chk("ovf_237", ovf0, 0);
      chk_dig("d0_237", 0, 0, 7'b1110000);
      chk_dig("d1_237", 0, 1, 7'b1111001);
      chk_dig("d2_237", 0, 2, 7'b1101101);
      chk_hold();

      // 123 then 99 held valid: 99 taken on the first IDLE cycle.
      vld0 = 1'b1; dat0 = 8'd123;
      step();
      dat0 = 8'd99;
      repeat (9) step();
      chk("ready_before_99", rdy0, 1);
      step();
      chk("took_99", rdy0, 0);
      vld0 = 1'b0;
      repeat (10) step();
      chk_dig("d0_99", 0, 0, 7'b1110011);
      chk_dig("d1_99", 0, 1, 7'b1110011);
      chk_dig("d2_99", 0, 2, LZ);

      // Leading zeros
      send(0, 8'd5);
      repeat (10) step();
      chk_dig("d0_5", 0, 0, 7'b1011011);
      chk_dig("d1_5", 0, 1, LZ);
      chk_dig("d2_5", 0, 2, LZ);

      // Two-digit overflow and recovery
      send(1, 8'd255);
      repeat (10) step();
      chk("ovf_255", ovf1, 1);
      chk_dig("d0_255", 1, 0, 7'b0000001);
      chk_dig("d1_255", 1, 1, 7'b0000001);
      send(1, 8'd42);
      repeat (10) step();
      chk("ovf_42", ovf1, 0);
      chk_dig("d1_42", 1, 1, 7'b0110011);
      chk_dig("d0_42", 1, 0, 7'b1101101);

      // Reset 4 cycles into converting 200
      send(0, 8'd200);
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", rdy0, 1);
      chk("mid_rst_den", den0, 3'b001);
      chk("mid_rst_seg", seg0, 7'b1111110);
      chk("mid_rst_ovf", ovf0, 0);
      #10 rst_n = 1'b1;
      repeat (15) step();
      chk("post_rst_ready", rdy0, 1);
      chk_dig("post_rst_d0", 0, 0, 7'b1111110);
      chk_dig("post_rst_d1", 0, 1, LZ);
      chk_dig("post_rst_d2", 0, 2, LZ);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multi-digit 7-segment display driver. Accepts a binary value through a valid/ready handshake and converts it to BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock. It then time-multiplexes the resulting digits onto a shared segment bus with one-hot digit enables. It sits between any binary status/counter source and the board's common-segment display, replacing per-digit combinational decoders.

## Interface

- `WIDTH`, 8: binary input width; legal 1..32.
- `DIGITS`, 3: number of display digits; legal 1..8.
- `SCAN_DIV`, 1000: clocks each digit stays enabled; legal ≥1.

- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: `in_data` valid.
- `in_data` in WIDTH: unsigned binary value to display.
- `in_ready` out 1: high only in IDLE; transfer on `in_valid && in_ready` at a rising edge.
- `seg` out 7: segments {a,b,c,d,e,f,g}, active-high.
- `dig_en` out DIGITS: one-hot, active-high; bit 0 = least-significant digit.
- `overflow` out 1: displayed value did not fit in DIGITS decimal digits.

## Operation

- Segment code, active-high {a..g}:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011
  - dash=0000001, blank=0000000
- FSM states: IDLE, CONVERT, LOAD.
  - IDLE: `in_ready`=1. On a transfer, capture `in_data` into the shift register and clear the BCD accumulator (4*DIGITS bits) and the bit counter. Set the overflow flag if `in_data` ≥ 10^DIGITS, computed at elaboration as a constant. Go to CONVERT.
  - CONVERT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, shift_reg} left by one. After exactly WIDTH shifts, go to LOAD.
  - LOAD: copy the BCD accumulator to the display register and the flag to `overflow`. Go to IDLE.
- While not in IDLE, `in_valid` is ignored and the input is not captured.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1.
  - On wrap, the digit index advances 0→1→…→DIGITS-1→0.
  - `dig_en` = one-hot of the index.
  - `seg` = code of display nibble[index], decoded combinationally from the registered index and display register.
  - When `overflow`=1, every digit shows dash.
- Scanning free-runs in every FSM state. The display register changes only in LOAD, so the shown value never tears mid-conversion.
- Simultaneous LOAD and scan step: both take effect on the same edge; the new digit shows the new value.
- Bits of the BCD accumulator above 4*DIGITS are discarded; the overflow flag covers that case.

## Timing

- Reset values (asynchronous, immediate on `rst_n`=0):
  - FSM=IDLE, `in_ready`=1
  - display register = 0, `overflow`=0
  - prescaler = 0, index = 0
  - `dig_en`=…001, `seg`=1111110 (1111110 also with blanking compiled in)
- Reset mid-conversion aborts the conversion. The previous display value is lost; the display shows 0.
- Latency, for a transfer at edge k:
  - edges k+1..k+WIDTH perform the shifts;
  - edge k+WIDTH+1 performs LOAD;
  - new `seg` is visible after edge k+WIDTH+1;
  - `in_ready`=1 again in the cycle after that edge.
- Throughput: one value per WIDTH+2 cycles.
- Each digit is enabled for exactly SCAN_DIV cycles. With SCAN_DIV=1 the index advances every cycle.

## Configuration

- `SEG7_LZB_EN` defined: leading-zero blanking.
  - Any digit above the most-significant nonzero digit shows blank.
  - Digit 0 is never blanked.
  - Blanking is not applied while `overflow`=1.
- Not defined: all digits are always shown, including leading zeros.

## Test plan

- Reset (WIDTH=8, DIGITS=3, SCAN_DIV=4): assert `rst_n`=0 mid-cycle → `in_ready`=1, `overflow`=0, `dig_en`=001, `seg`=1111110 immediately.
- Conversion: transfer 237 at edge k → `in_ready`=0 for edges k+1..k+9. After k+9, the scan shows:
  - `dig_en`=001 with `seg`=1110000
  - `dig_en`=010 with `seg`=1111001
  - `dig_en`=100 with `seg`=1101101
  - each digit held for exactly 4 cycles.
- Busy input: hold `in_valid`=1 with 99 during a 237 conversion → 99 is not captured; the display shows 237. 99 is accepted on the first IDLE cycle only if still valid.
- Overflow (WIDTH=8, DIGITS=2): transfer 255 → `overflow`=1, both digits 0000001. A following transfer of 42 → `overflow`=0, digits 0110011 (tens) and 1101101 (units).
- Reset mid-operation: drop `rst_n` 4 cycles after transferring 200 → FSM=IDLE, display 000, no later LOAD.
- Blanking: transfer 5.
  - With `SEG7_LZB_EN`: digit 0 = 1011011, digits 1-2 = 0000000.
  - Without it: digits 1-2 = 1111110.
